// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Function : RISC-V fetch stage. Owns the PC, captures the ROM word into IF/ID,
//            and handles stalls, flushing redirects and misaligned targets.
// Revision : 1.0
// ============================================================================
module if_stage #(
   parameter int                  PC_WIDTH  = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = 16'h0000,
   parameter logic [31:0]         NOP_INSTR = 32'h00000013,
   parameter int                  CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [PC_WIDTH-1:0]  pc,
   input  logic [31:0]          instr,
   input  logic                 id_stall,
   input  logic                 redirect,
   input  logic [PC_WIDTH-1:0]  redirect_pc,
   output logic                 if_id_valid,
   output logic [31:0]          if_id_instr,
   output logic [PC_WIDTH-1:0]  if_id_pc,
   output logic                 misalign_err,
   output logic [CNT_WIDTH-1:0] fetch_count
);

   localparam logic [PC_WIDTH-1:0]  c_PC_STEP  = PC_WIDTH'(4);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [PC_WIDTH-1:0]  c_PC_ZERO  = '0;

   logic [PC_WIDTH-1:0]  r_pc;
   logic                 r_valid;
   logic [31:0]          r_instr;
   logic [PC_WIDTH-1:0]  r_if_id_pc;
   logic                 r_misalign;
   logic [CNT_WIDTH-1:0] r_count;

   logic [PC_WIDTH-1:0]  w_pc_nxt;
   logic                 w_valid_nxt;
   logic [31:0]          w_instr_nxt;
   logic [PC_WIDTH-1:0]  w_if_id_pc_nxt;
   logic                 w_misalign_nxt;
   logic [CNT_WIDTH-1:0] w_count_nxt;

   // Priority: redirect beats stall beats advance; reset handled in the register.
   always_comb begin
      w_pc_nxt       = r_pc;
      w_valid_nxt    = r_valid;
      w_instr_nxt    = r_instr;
      w_if_id_pc_nxt = r_if_id_pc;
      w_misalign_nxt = 1'b0;
      w_count_nxt    = r_count;
      if (redirect) begin
         // Target is force-aligned; a nonzero low pair is only flagged.
         w_pc_nxt       = {redirect_pc[PC_WIDTH-1:2], 2'b00};
         w_valid_nxt    = 1'b0;
         w_instr_nxt    = NOP_INSTR;
         w_if_id_pc_nxt = c_PC_ZERO;
         w_misalign_nxt = (redirect_pc[1:0] != 2'b00);
      end else if (!id_stall) begin
         w_pc_nxt       = r_pc + c_PC_STEP;
         w_valid_nxt    = 1'b1;
         w_instr_nxt    = instr;
         w_if_id_pc_nxt = r_pc;
         w_count_nxt    = r_count + c_CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
         r_valid    <= 1'b0;
         r_instr    <= NOP_INSTR;
         r_if_id_pc <= c_PC_ZERO;
         r_misalign <= 1'b0;
         r_count    <= '0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_instr    <= w_instr_nxt;
         r_if_id_pc <= w_if_id_pc_nxt;
         r_misalign <= w_misalign_nxt;
         r_count    <= w_count_nxt;
      end
   end

   assign pc           = r_pc;
   assign if_id_valid  = r_valid;
   assign if_id_instr  = r_instr;
   assign if_id_pc     = r_if_id_pc;
   assign misalign_err = r_misalign;
   assign fetch_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// Directed-vector bench for if_stage with a combinational ROM model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] pc;
   logic [31:0] instr;
   logic        id_stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [15:0] if_id_pc;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   // Three programmed words; every other address returns a tag of its address.
   always_comb begin
      case (pc)
         16'h0000: instr = 32'h00300413;
         16'h0004: instr = 32'h00000013;
         16'h0008: instr = 32'h00340413;
         default:  instr = {16'hC0DE, pc};
      endcase
   end

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .instr        (instr),
      .id_stall     (id_stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .if_id_valid  (if_id_valid),
      .if_id_instr  (if_id_instr),
      .if_id_pc     (if_id_pc),
      .misalign_err (misalign_err),
      .fetch_count  (fetch_count)
   );

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic [15:0] e_pc;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [15:0] e_ifpc;
      logic        e_mis;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vt[19];

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input vec_t v);
      n_vec++;
      chk("pc",      idx, 32'(pc),           32'(v.e_pc));
      chk("valid",   idx, 32'(if_id_valid),  32'(v.e_valid));
      chk("instr",   idx, if_id_instr,       v.e_instr);
      chk("if_id_pc",idx, 32'(if_id_pc),     32'(v.e_ifpc));
      chk("misalign",idx, 32'(misalign_err), 32'(v.e_mis));
      chk("count",   idx, fetch_count,       v.e_cnt);
      chk("pc_align",idx, 32'(pc[1:0]),      32'd0);
   endtask

   initial begin
      //         rst   stl   red   rpc       pc        v     instr          ifpc      mis   cnt
      vt[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 32'h00000013, 16'h0000, 1'b0, 32'd0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 32'h00300413, 16'h0000, 1'b0, 32'd1};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 32'h00000013, 16'h0004, 1'b0, 32'd2};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 32'h00000013, 16'h0004, 1'b0, 32'd2};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 32'h00000013, 16'h0004, 1'b0, 32'd2};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 32'h00000013, 16'h0004, 1'b0, 32'd2};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h000C, 1'b1, 32'h00340413, 16'h0008, 1'b0, 32'd3};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0010, 1'b0, 32'h00000013, 16'h0000, 1'b0, 32'd3};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0014, 1'b1, 32'hC0DE0010, 16'h0010, 1'b0, 32'd4};
      vt[9]  = '{1'b0, 1'b1, 1'b1, 16'h0016, 16'h0014, 1'b0, 32'h00000013, 16'h0000, 1'b1, 32'd4};
      vt[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0014, 1'b0, 32'h00000013, 16'h0000, 1'b0, 32'd4};
      vt[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0018, 1'b1, 32'hC0DE0014, 16'h0014, 1'b0, 32'd5};
      vt[12] = '{1'b0, 1'b0, 1'b1, 16'hFFFC, 16'hFFFC, 1'b0, 32'h00000013, 16'h0000, 1'b0, 32'd5};
      vt[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 32'hC0DEFFFC, 16'hFFFC, 1'b0, 32'd6};
      vt[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 32'h00300413, 16'h0000, 1'b0, 32'd7};
      vt[15] = '{1'b1, 1'b1, 1'b1, 16'h0022, 16'h0000, 1'b0, 32'h00000013, 16'h0000, 1'b0, 32'd0};
      vt[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 32'h00300413, 16'h0000, 1'b0, 32'd1};
      vt[17] = '{1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 32'h00000013, 16'h0000, 1'b1, 32'd1};
      vt[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 32'h00300413, 16'h0000, 1'b0, 32'd2};

      rst = 1'b1; id_stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         rst = vt[i].rst; id_stall = vt[i].stall;
         redirect = vt[i].redir; redirect_pc = vt[i].rpc;
         @(posedge clk);
         #1;
         check_all(i, vt[i]);
      end

      // pc must not react combinationally to redirect/stall before the edge.
      @(negedge clk);
      rst = 1'b0; id_stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
      #1;
      n_vec++;
      chk("pc_comb", 19, 32'(pc), 32'h0004);
      @(posedge clk);
      #1;
      n_vec++;
      chk("pc_redir", 20, 32'(pc), 32'h0100);

      // Free run from 0x0100 against a running model of pc and count.
      begin
         logic [15:0] m_pc;
         logic [31:0] m_cnt;
         m_pc = 16'h0100; m_cnt = 32'd2;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            id_stall = 1'b0; redirect = 1'b0;
            @(posedge clk);
            #1;
            n_vec++;
            chk("run_ifpc",  21 + k, 32'(if_id_pc), 32'(m_pc));
            chk("run_instr", 21 + k, if_id_instr, {16'hC0DE, m_pc});
            m_pc  = m_pc + 16'd4;
            m_cnt = m_cnt + 32'd1;
            chk("run_pc",    21 + k, 32'(pc), 32'(m_pc));
            chk("run_count", 21 + k, fetch_count, m_cnt);
            chk("run_valid", 21 + k, 32'(if_id_valid), 32'd1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
